// File: rtl/phase_det_pkg.sv
// Shared constants, error codes, FSM state type and the phase fold helper
// for the digital phase detector.
package phase_det_pkg;

    localparam int unsigned FULL_TURN = 360;
    localparam int unsigned HALF_TURN = 180;

    // Quotient width: raw phase spans 0..359.
    localparam int unsigned QUOT_W = 9;

    localparam logic [1:0] ERR_NOSIG = 2'b01;
    localparam logic [1:0] ERR_SHORT = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic {IDLE, MEAS} det_state_e;

    // Folds a raw 0..359 angle into {direction, magnitude 0..180}.
    function automatic logic [QUOT_W:0] fold_phase(input logic [QUOT_W-1:0] raw);
        if (raw <= QUOT_W'(HALF_TURN)) begin
            return {1'b0, raw};
        end
        return {1'b1, QUOT_W'(FULL_TURN) - raw};
    endfunction

endpackage

// File: rtl/phase_div.sv
// Restoring divider producing a 9-bit quotient, one bit per cycle.
// The first iteration runs on the start cycle directly from the inputs.
module phase_div
    import phase_det_pkg::*;
#(
    parameter int unsigned NUM_W = 25
) (
    input  logic              aclk,
    input  logic              aclr_n,
    input  logic              start,
    input  logic [NUM_W-1:0]  numerator,
    input  logic [NUM_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [QUOT_W-1:0] quotient
);

    logic [NUM_W-1:0]  rem_q, rem_d, rem_cur;
    logic [NUM_W-1:0]  dvs_q, dvs_d, dvs_cur;
    logic [QUOT_W-1:0] quo_q, quo_d, quo_cur;
    logic [3:0]        iter_q, iter_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              take;

    // One restoring step per cycle; divisor walks right from its aligned position.
    always_comb begin
        rem_cur = start ? numerator : rem_q;
        dvs_cur = start ? divisor : dvs_q;
        quo_cur = start ? '0 : quo_q;
        take    = (rem_cur >= dvs_cur);
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start || busy_q) begin
            rem_d = take ? (rem_cur - dvs_cur) : rem_cur;
            dvs_d = dvs_cur >> 1;
            quo_d = {quo_cur[QUOT_W-2:0], take};
            if (start) begin
                iter_d = 4'd1;
                busy_d = 1'b1;
            end else if (iter_q == 4'(QUOT_W - 1)) begin
                iter_d = 4'd0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                iter_d = iter_q + 4'd1;
            end
        end
    end

    // Divider state; reset aborts any division in flight.
    always_ff @(posedge aclk or negedge aclr_n) begin
        if (!aclr_n) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/digital_phase_detector.sv
// Measures the delay from each reference rise to the first signal rise, converts
// it to whole degrees of the reference period and reports magnitude plus lead/lag.
// Optional macro PHASE_DET_SYNC_EN adds 2-flop input synchronisers.
module digital_phase_detector
    import phase_det_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MIN_PERIOD = 12
) (
    input  logic       aclk,
    input  logic       aclr_n,
    input  logic       ref_in,
    input  logic       sig_in,
    output logic [8:0] phase_deg,
    output logic       direction,
    output logic       valid,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int unsigned      NUM_W   = CNT_W + QUOT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);

    logic ref_s, sig_s;
    logic ref_prev_q, sig_prev_q;
    logic ref_rise, sig_rise;

`ifdef PHASE_DET_SYNC_EN
    logic [1:0] ref_sync_q, sig_sync_q;

    // Two-flop synchronisers for asynchronous inputs.
    always_ff @(posedge aclk or negedge aclr_n) begin
        if (!aclr_n) begin
            ref_sync_q <= '0;
            sig_sync_q <= '0;
        end else begin
            ref_sync_q <= {ref_sync_q[0], ref_in};
            sig_sync_q <= {sig_sync_q[0], sig_in};
        end
    end

    assign ref_s = ref_sync_q[1];
    assign sig_s = sig_sync_q[1];
`else
    assign ref_s = ref_in;
    assign sig_s = sig_in;
`endif

    assign ref_rise = ref_s & ~ref_prev_q;
    assign sig_rise = sig_s & ~sig_prev_q;

    det_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              have_q, have_d;
    logic [CNT_W-1:0]  dly_q, dly_d;
    logic              close_q;
    logic [CNT_W-1:0]  per_q;
    logic              snap_have_q;
    logic [CNT_W-1:0]  snap_dly_q;
    logic              start_q, start_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [8:0]        phase_q, phase_d;
    logic              dir_q, dir_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic [1:0]        code_q, code_d;
    logic              timeout;

    logic              div_busy, div_done;
    logic [QUOT_W-1:0] div_quot;
    logic [NUM_W-1:0]  div_den;

    assign timeout = (state_q == MEAS) && !ref_rise && (cnt_q == CNT_MAX);
    assign div_den = {1'b0, per_q, 8'b0};

    // Period counter and first-sig-rise capture for the period in progress.
    always_comb begin
        cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        have_d = have_q;
        dly_d  = dly_q;
        if (ref_rise) begin
            cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
            have_d = sig_rise;  // coincident edges mean zero delay
            dly_d  = '0;
        end else if (sig_rise && !have_q) begin
            have_d = 1'b1;
            dly_d  = cnt_q;
        end
    end

    // FSM: first ref rise arms measurement; saturation drops back to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ref_rise) state_d = MEAS;
            MEAS: if (timeout)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Period checks, divider launch, and result fold into the output registers.
    always_comb begin
        error_d = 1'b0;
        code_d  = code_q;
        start_d = 1'b0;
        num_d   = num_q;
        valid_d = 1'b0;
        phase_d = phase_q;
        dir_d   = dir_q;
        if (close_q) begin
            if (per_q < MIN_P) begin
                error_d = 1'b1;
                code_d  = ERR_SHORT;
            end else if (!snap_have_q) begin
                error_d = 1'b1;
                code_d  = ERR_NOSIG;
            end else if (!div_busy) begin
                start_d = 1'b1;
                num_d   = NUM_W'(snap_dly_q) * NUM_W'(FULL_TURN);
            end
        end
        if (timeout) begin
            error_d = 1'b1;
            code_d  = ERR_TMO;
        end
        if (div_done && !error_d) begin
            valid_d          = 1'b1;
            {dir_d, phase_d} = fold_phase(div_quot);
        end
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Edge history, counters, period snapshot and output registers.
    always_ff @(posedge aclk or negedge aclr_n) begin
        if (!aclr_n) begin
            ref_prev_q  <= 1'b0;
            sig_prev_q  <= 1'b0;
            cnt_q       <= '0;
            have_q      <= 1'b0;
            dly_q       <= '0;
            close_q     <= 1'b0;
            per_q       <= '0;
            snap_have_q <= 1'b0;
            snap_dly_q  <= '0;
            start_q     <= 1'b0;
            num_q       <= '0;
            phase_q     <= '0;
            dir_q       <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= '0;
        end else begin
            ref_prev_q <= ref_s;
            sig_prev_q <= sig_s;
            cnt_q      <= cnt_d;
            have_q     <= have_d;
            dly_q      <= dly_d;
            close_q    <= ref_rise && (state_q == MEAS);
            if (ref_rise) begin
                // Snapshot the period that this rise closes, before the reload.
                per_q       <= cnt_q;
                snap_have_q <= have_q;
                snap_dly_q  <= dly_q;
            end
            start_q <= start_d;
            num_q   <= num_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    phase_div #(
        .NUM_W (NUM_W)
    ) u_div (
        .aclk      (aclk),
        .aclr_n    (aclr_n),
        .start     (start_q),
        .numerator (num_q),
        .divisor   (div_den),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot)
    );

    assign phase_deg = phase_q;
    assign direction = dir_q;
    assign valid     = valid_q;
    assign error     = error_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_digital_phase_detector.sv
// Directed bench for digital_phase_detector with CNT_W=6 so the timeout is reachable.
module tb_digital_phase_detector;

    localparam int unsigned CNT_W = 6;

    logic       aclk = 1'b0;
    logic       aclr_n;
    logic       ref_in;
    logic       sig_in;
    logic [8:0] phase_deg;
    logic       direction;
    logic       valid;
    logic       error;
    logic [1:0] err_code;

    always #5 aclk = ~aclk;

    digital_phase_detector #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (12)
    ) dut (
        .aclk      (aclk),
        .aclr_n    (aclr_n),
        .ref_in    (ref_in),
        .sig_in    (sig_in),
        .phase_deg (phase_deg),
        .direction (direction),
        .valid     (valid),
        .error     (error),
        .err_code  (err_code)
    );

    int unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Event recorder: counts pulses and remembers the latest of each kind.
    int unsigned tot_valid = 0, tot_error = 0, n_overlap = 0;
    int unsigned v_cyc = 0, v_phase = 0, v_dir = 0;
    int unsigned e_cyc = 0, e_code = 0, e_phase = 0, e_dir = 0;
    always @(negedge aclk) begin
        if (valid) begin
            tot_valid <= tot_valid + 1;
            v_cyc     <= cyc;
            v_phase   <= 32'(phase_deg);
            v_dir     <= 32'(direction);
        end
        if (error) begin
            tot_error <= tot_error + 1;
            e_cyc     <= cyc;
            e_code    <= 32'(err_code);
            e_phase   <= 32'(phase_deg);
            e_dir     <= 32'(direction);
        end
        if (valid && error) n_overlap <= n_overlap + 1;
    end

    int unsigned n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Shifted square wave: high for the first p/2 cycles after offset d.
    function automatic logic wave(input int c, input int p, input int d);
        return ((c - d + p) % p) < (p / 2);
    endfunction

    // Drives len cycles of one period; n is the edge where its ref rise is seen.
    task automatic drive_period(input int p, input int d, input bit sig_on, input int len,
                                output int unsigned n);
        n = 0;
        for (int c = 0; c < len; c++) begin
            if (c == 0) n = cyc + 1;
            ref_in = (c < p / 2);
            sig_in = sig_on && wave(c, p, d);
            tick();
        end
    endtask

    // Holds ref low with sig at its end-of-period level so no spurious sig rise occurs.
    task automatic idle(input int n, input int p, input int d, input bit sig_on);
        ref_in = 1'b0;
        sig_in = sig_on && wave(p - 1, p, d);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        aclr_n = 1'b0;
        ref_in = 1'b0;
        sig_in = 1'b0;
        repeat (3) tick();
        aclr_n = 1'b1;
        tick();
    endtask

    task automatic run_valid(input string tag, input int p, input int d,
                             input int unsigned exp_phase, input int unsigned exp_dir);
        int unsigned na, nb, bv, be;
        do_reset();
        bv = tot_valid;
        be = tot_error;
        idle(5, p, d, 1'b1);
        drive_period(p, d, 1'b1, p, na);
        drive_period(p, d, 1'b1, p, nb);
        idle(20, p, d, 1'b1);
        check_eq({tag, "_nvalid"}, tot_valid - bv, 1);
        check_eq({tag, "_cycle"}, v_cyc, nb + 11);
        check_eq({tag, "_phase"}, v_phase, exp_phase);
        check_eq({tag, "_dir"}, v_dir, exp_dir);
        check_eq({tag, "_nerr"}, tot_error - be, 0);
    endtask

    initial begin
        int unsigned na, nb, nc, nd, ne, bv, be;
        aclr_n = 1'b0;
        ref_in = 1'b0;
        sig_in = 1'b0;
        #1;
        check_eq("rst_phase", 32'(phase_deg), 0);
        check_eq("rst_dir", 32'(direction), 0);
        check_eq("rst_valid", 32'(valid), 0);
        check_eq("rst_error", 32'(error), 0);
        check_eq("rst_code", 32'(err_code), 0);

        run_valid("p20d5", 20, 5, 90, 0);
        run_valid("p20d15", 20, 15, 90, 1);
        run_valid("p20d10", 20, 10, 180, 0);
        run_valid("p13d0", 13, 0, 0, 0);
        run_valid("p13d1", 13, 1, 27, 0);
        run_valid("p21d17", 21, 17, 69, 1);

        // Short period closed after a good result.
        do_reset();
        bv = tot_valid;
        be = tot_error;
        idle(5, 20, 5, 1'b1);
        drive_period(20, 5, 1'b1, 20, na);
        drive_period(20, 5, 1'b1, 20, nb);
        drive_period(8, 2, 1'b1, 8, nc);
        drive_period(20, 5, 1'b1, 20, nd);
        idle(15, 20, 5, 1'b1);
        check_eq("short_nvalid", tot_valid - bv, 2);
        check_eq("short_vcycle", v_cyc, nc + 11);
        check_eq("short_nerr", tot_error - be, 1);
        check_eq("short_ecycle", e_cyc, nd + 1);
        check_eq("short_code", e_code, 2);
        check_eq("short_phase_kept", e_phase, 90);
        check_eq("short_dir_kept", e_dir, 0);
        check_eq("short_code_held", 32'(err_code), 2);

        // Period with no sig edge.
        do_reset();
        bv = tot_valid;
        be = tot_error;
        idle(5, 20, 5, 1'b1);
        drive_period(20, 5, 1'b1, 20, na);
        drive_period(20, 5, 1'b0, 20, nb);
        drive_period(20, 5, 1'b1, 20, nc);
        idle(15, 20, 5, 1'b1);
        check_eq("nosig_nvalid", tot_valid - bv, 1);
        check_eq("nosig_nerr", tot_error - be, 1);
        check_eq("nosig_ecycle", e_cyc, nc + 1);
        check_eq("nosig_code", e_code, 1);
        check_eq("nosig_phase_kept", e_phase, 90);

        // Reference stops: timeout, then two rises before the next result.
        do_reset();
        bv = tot_valid;
        be = tot_error;
        idle(5, 20, 5, 1'b1);
        drive_period(20, 5, 1'b1, 20, na);
        idle(50, 20, 5, 1'b1);
        check_eq("tmo_nerr", tot_error - be, 1);
        check_eq("tmo_ecycle", e_cyc, na + 63);
        check_eq("tmo_code", e_code, 3);
        check_eq("tmo_nvalid", tot_valid - bv, 0);
        drive_period(20, 5, 1'b1, 20, nb);
        drive_period(20, 5, 1'b1, 20, nc);
        idle(20, 20, 5, 1'b1);
        check_eq("tmo_after_nvalid", tot_valid - bv, 1);
        check_eq("tmo_after_vcycle", v_cyc, nc + 11);
        check_eq("tmo_after_phase", v_phase, 90);

        // Reset in the middle of a division.
        do_reset();
        idle(5, 20, 15, 1'b1);
        drive_period(20, 15, 1'b1, 20, na);
        drive_period(20, 15, 1'b1, 20, nb);
        drive_period(20, 15, 1'b1, 6, nc);
        check_eq("abort_pre_phase", 32'(phase_deg), 90);
        check_eq("abort_pre_dir", 32'(direction), 1);
        aclr_n = 1'b0;
        #1;
        check_eq("abort_phase", 32'(phase_deg), 0);
        check_eq("abort_dir", 32'(direction), 0);
        check_eq("abort_code", 32'(err_code), 0);
        bv = tot_valid;
        idle(10, 20, 5, 1'b1);
        aclr_n = 1'b1;
        idle(5, 20, 5, 1'b1);
        check_eq("abort_no_valid", tot_valid - bv, 0);
        drive_period(20, 5, 1'b1, 20, nd);
        drive_period(20, 5, 1'b1, 20, ne);
        idle(20, 20, 5, 1'b1);
        check_eq("abort_after_nvalid", tot_valid - bv, 1);
        check_eq("abort_after_vcycle", v_cyc, ne + 11);
        check_eq("abort_after_phase", v_phase, 90);
        check_eq("abort_after_dir", v_dir, 0);

        check_eq("valid_error_overlap", n_overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
